// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory bus slice seen by the UART: store strobe/address/data in, hit and read data back.
// Read side is combinational so single-cycle loads complete in the issuing cycle.
interface mmio_uart_tx_if;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic        hit;
  logic [31:0] memreaddata;

  modport master (
    output memwrite, memaddr, memwritedata,
    input  hit, memreaddata
  );

  modport slave (
    input  memwrite, memaddr, memwritedata,
    output hit, memreaddata
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter; push-to-txd-fall latency is one edge, frame is 10*div cycles.
// No backpressure on the bus: a store to a full FIFO is dropped and raises the sticky overflow flag.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF0000,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          txd,
  output logic          busy
);

  localparam int         AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] DEPTH = 4'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] R_TXDATA = 2'd0;
  localparam logic [1:0] R_STATUS = 2'd1;
  localparam logic [1:0] R_BAUD   = 2'd2;

  logic [1:0]    state;
  logic [7:0]    shift;
  logic [2:0]    bitidx;
  logic [15:0]   baud_cnt;
  logic [15:0]   div;
  logic [15:0]   eff_div;
  logic [15:0]   reload;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [3:0]    count;
  logic          overflow;
  logic [7:0]    head_dat;

  logic [1:0]    sel;
  logic          wr_en;
  logic          push_vld;
  logic          push_ok;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic          bit_end;
  logic          shifter_active;
  logic          unused_bits;

  // Byte lanes and low address bits the register map never looks at.
  assign unused_bits = ^{bus.memaddr[1:0], bus.memwritedata[31:16]};

  // ------------------------------------------------------------------
  // Bus decode and combinational read path
  // ------------------------------------------------------------------
  assign bus.hit  = (bus.memaddr[31:4] == BASE_ADDR[31:4]);
  assign sel      = bus.memaddr[3:2];
  assign wr_en    = bus.memwrite & bus.hit;
  assign push_vld = wr_en & (sel == R_TXDATA);

  assign fifo_empty     = (count == 4'd0);
  assign fifo_full      = (count == DEPTH);
  assign shifter_active = (state != S_IDLE);
  assign head_dat       = fifo_mem[rd_ptr];

  always_comb begin
    bus.memreaddata = 32'd0;
    if (bus.hit) begin
      case (sel)
        R_STATUS: bus.memreaddata = {24'd0, count, overflow, shifter_active, fifo_empty, fifo_full};
        R_BAUD:   bus.memreaddata = {16'd0, div};
        default:  bus.memreaddata = 32'd0;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Baud divider register
  // ------------------------------------------------------------------
  assign eff_div = (div == 16'd0) ? 16'd1 : div;
  assign reload  = eff_div - 16'd1;
  assign bit_end = (baud_cnt == 16'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= 16'(CLKS_PER_BIT);
    end else if (wr_en && (sel == R_BAUD)) begin
      div <= bus.memwritedata[15:0];
    end
  end

  // ------------------------------------------------------------------
  // Transmit FIFO
  // ------------------------------------------------------------------
  // A pop in the same cycle frees the slot, so a full FIFO still accepts then.
  assign pop     = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  assign push_ok = push_vld && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= bus.memwritedata[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (push_vld && !push_ok) begin
        overflow <= 1'b1;
      end else if (wr_en && (sel == R_STATUS) && bus.memwritedata[3]) begin
        overflow <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Serializer FSM; txd is registered so the line never glitches
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      shift    <= 8'd0;
      bitidx   <= 3'd0;
      baud_cnt <= 16'd0;
      txd      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            shift    <= head_dat;
            state    <= S_START;
            txd      <= 1'b0;
            baud_cnt <= reload;
          end
        end

        S_START: begin
          if (bit_end) begin
            state    <= S_DATA;
            bitidx   <= 3'd0;
            txd      <= shift[0];
            baud_cnt <= reload;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= reload;
            if (bitidx == 3'd7) begin
              state <= S_STOP;
              txd   <= 1'b1;
            end else begin
              bitidx <= bitidx + 3'd1;
              shift  <= {1'b0, shift[7:1]};
              txd    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            // Back-to-back frames: next start bit follows the stop bit with no idle gap.
            if (!fifo_empty) begin
              shift    <= head_dat;
              state    <= S_START;
              txd      <= 1'b0;
              baud_cnt <= reload;
            end else begin
              state    <= S_IDLE;
              txd      <= 1'b1;
              baud_cnt <= 16'd0;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end

        default: begin
          state    <= S_IDLE;
          txd      <= 1'b1;
          baud_cnt <= 16'd0;
        end
      endcase
    end
  end

  assign busy = shifter_active || !fifo_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, frame timing, overflow, divider change, async reset.
// Stimulus is driven on the falling edge; outputs are sampled on the falling edge (plus #1 for reads).
module tb_mmio_uart_tx;

  logic clk;
  logic reset;
  logic txd;
  logic busy;
  int   nvec;
  int   nerr;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR    (32'hFFFF0000),
    .FIFO_DEPTH   (4),
    .CLKS_PER_BIT (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .txd   (txd),
    .busy  (busy)
  );

  localparam logic [31:0] A_TX   = 32'hFFFF0000;
  localparam logic [31:0] A_STAT = 32'hFFFF0004;
  localparam logic [31:0] A_BAUD = 32'hFFFF0008;
  localparam logic [31:0] A_RSVD = 32'hFFFF000C;
  localparam logic [31:0] A_MISS = 32'hFFFF0010;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Store: presented in the low phase, taken at the next rising edge; returns at the following falling edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.memaddr      = a;
    bus.memwritedata = d;
    bus.memwrite     = 1'b1;
    @(negedge clk);
    bus.memwrite     = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.memaddr = a;
    #1;
    check(tag, bus.memreaddata, exp);
  endtask

  // Checks txd over frame positions first..last (0 start, 1..8 data LSB first, 9 stop),
  // one sample per falling edge; positions below split last lo cycles, the rest hi cycles.
  task automatic frame(input string tag, input logic [7:0] b, input int first, input int last,
                       input int lo, input int hi, input int split);
    for (int p = first; p <= last; p++) begin
      logic e;
      int   n;
      e = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : b[p-1];
      n = (p < split) ? lo : hi;
      for (int c = 0; c < n; c++) begin
        check($sformatf("%s pos%0d cyc%0d", tag, p, c), {31'd0, txd}, {31'd0, e});
        @(negedge clk);
      end
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int lows;
    nvec = 0;
    nerr = 0;
    reset = 1'b1;
    bus.memwrite     = 1'b0;
    bus.memaddr      = 32'd0;
    bus.memwritedata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset and idle state, address decode
    check("rst txd", {31'd0, txd}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    rd_chk("rst status", A_STAT, 32'h02);
    check("hit in window", {31'd0, bus.hit}, 32'd1);
    rd_chk("rst bauddiv", A_BAUD, 32'd16);
    rd_chk("txdata reads 0", A_TX, 32'd0);
    rd_chk("reserved reads 0", A_RSVD, 32'd0);
    rd_chk("miss rdata", A_MISS, 32'd0);
    check("miss hit", {31'd0, bus.hit}, 32'd0);
    wr(A_RSVD, 32'hFFFF_FFFF);
    rd_chk("reserved write ignored", A_STAT, 32'h02);

    // Single frame, div 4, 0x55
    wr(A_BAUD, 32'hABCD_0004);
    rd_chk("bauddiv=4", A_BAUD, 32'd4);
    wr(A_TX, 32'h0000_0055);
    check("push edge txd still 1", {31'd0, txd}, 32'd1);
    check("push edge busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("frame busy", {31'd0, busy}, 32'd1);
    frame("f55", 8'h55, 0, 9, 4, 4, 10);
    check("after 55 busy", {31'd0, busy}, 32'd0);
    check("after 55 txd", {31'd0, txd}, 32'd1);

    // Back-to-back frames, div 2
    wr(A_BAUD, 32'd2);
    wr(A_TX, 32'hA1);
    wr(A_TX, 32'h0F);
    rd_chk("status count 1 active", A_STAT, 32'h14);
    frame("fA1", 8'hA1, 0, 9, 2, 2, 10);
    frame("f0F", 8'h0F, 0, 9, 2, 2, 10);
    check("after 0F busy", {31'd0, busy}, 32'd0);

    // Overflow: 6 stores in 6 cycles with a slow divider, 5 accepted
    wr(A_BAUD, 32'd100);
    for (int i = 0; i < 6; i++) wr(A_TX, 32'h30 + i);
    rd_chk("status full ovf", A_STAT, 32'h4D);
    wr(A_STAT, 32'h0000_0008);
    rd_chk("status ovf cleared", A_STAT, 32'h45);
    pulse_reset();

    // Divider 0 behaves as 1
    wr(A_BAUD, 32'd0);
    rd_chk("bauddiv=0 readback", A_BAUD, 32'd0);
    wr(A_TX, 32'h3C);
    @(negedge clk);
    frame("f3C", 8'h3C, 0, 9, 1, 1, 10);
    check("after 3C busy", {31'd0, busy}, 32'd0);

    // Divider change mid-frame: store lands on the edge that starts data bit 3
    wr(A_TX, 32'hC5);
    @(negedge clk);
    frame("fC5a", 8'hC5, 0, 2, 1, 1, 10);
    check("fC5 bit2", {31'd0, txd}, 32'd1);
    wr(A_BAUD, 32'd8);
    frame("fC5b", 8'hC5, 4, 9, 1, 8, 5);
    check("after C5 busy", {31'd0, busy}, 32'd0);

    // Async reset in data bit 2 with 3 bytes queued
    wr(A_BAUD, 32'd4);
    wr(A_TX, 32'h00);
    wr(A_TX, 32'h11);
    wr(A_TX, 32'h22);
    wr(A_TX, 32'h33);
    rd_chk("status 3 queued", A_STAT, 32'h34);
    repeat (11) @(negedge clk);
    check("pre-reset bit2 txd", {31'd0, txd}, 32'd0);
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async reset txd", {31'd0, txd}, 32'd1);
    check("async reset busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rd_chk("post-reset status", A_STAT, 32'h02);
    rd_chk("post-reset bauddiv", A_BAUD, 32'd16);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check("no frames after reset", lows, 32'd0);
    check("idle busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
